// File: rtl/multi_team_scoreboard_pkg.sv
// Shared types and helpers for multi_team_scoreboard.
// Build option: define UNDO_EN to enable the one-level undo record.
package scoreboard_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    MODE_P1 = 2'd0,
    MODE_P2 = 2'd1,
    MODE_P3 = 2'd2
  } mode_e;

  // Bit positions of the key/event vectors
  localparam int K_TEAM  = 0;
  localparam int K_MODE  = 1;
  localparam int K_COUNT = 2;
  localparam int K_CLEAR = 3;
  localparam int K_UNDO  = 4;
  localparam int N_KEYS  = 5;

  // Largest representable score with n BCD digits
  function automatic int bcd_max(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r - 1;
  endfunction

  // Index width that stays at least 1 bit for a single-entry range
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_team_scoreboard_bcd_add_sat.sv
// Combinational N_DIGITS-digit BCD adder with a small addend and saturation
// to all-9s when the sum overflows the available digits.
module bcd_add_sat
  import scoreboard_pkg::*;
#(
  parameter int N_DIGITS = 2
) (
  input  logic [N_DIGITS*4-1:0] I_a,
  input  logic [1:0]            I_addend,
  output logic [N_DIGITS*4-1:0] O_sum,
  output logic                  O_sat
);

  logic [N_DIGITS*4-1:0] raw_sum;
  logic [1:0]            carry;
  logic [4:0]            dsum;

  // Ripple the addend through the digits, then clamp on final carry
  always_comb begin
    raw_sum = '0;
    carry   = I_addend;
    dsum    = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      dsum = 5'(I_a[i*4 +: 4]) + 5'(carry);
      if (dsum > 5'd9) begin
        raw_sum[i*4 +: 4] = 4'(dsum - 5'd10);
        carry             = 2'd1;
      end else begin
        raw_sum[i*4 +: 4] = dsum[3:0];
        carry             = 2'd0;
      end
    end
    O_sat = (carry != 2'd0);
    O_sum = raw_sum;
    if (O_sat) begin
      for (int unsigned i = 0; i < N_DIGITS; i++) O_sum[i*4 +: 4] = bcd_digit_t'(4'd9);
    end
  end

endmodule

// File: rtl/multi_team_scoreboard.sv
// Multi-team BCD scoreboard with +1/+2/+3 increments, saturation, clear and a
// time-multiplexed digit scan. Build option: UNDO_EN adds a one-level undo.
module multi_team_scoreboard
  import scoreboard_pkg::*;
#(
  parameter int N_TEAMS  = 2,
  parameter int N_DIGITS = 2,
  parameter int SCAN_DIV = 50000
) (
  input  logic                            I_clk,
  input  logic                            I_rst_n,
  input  logic                            I_key_team,
  input  logic                            I_key_mode,
  input  logic                            I_key_count,
  input  logic                            I_key_clear,
  input  logic                            I_key_undo,
  output logic [width_of(N_TEAMS)-1:0]    O_team_sel,
  output logic [1:0]                      O_mode,
  output logic [N_TEAMS*N_DIGITS*4-1:0]   O_bcd,
  output logic                            O_sat,
  output logic [3:0]                      O_scan_digit,
  output logic [N_TEAMS*N_DIGITS-1:0]     O_scan_sel
);

  localparam int TW = width_of(N_TEAMS);
  localparam int SW = N_DIGITS * 4;
  localparam int NS = N_TEAMS * N_DIGITS;
  localparam int IW = width_of(NS);
  localparam int DW = $clog2(SCAN_DIV);

  logic [N_KEYS-1:0]  key_in;
  logic [N_KEYS-1:0]  key_q, key_d;
  logic [N_KEYS-1:0]  evt_q, evt_d;
  logic [TW-1:0]      team_q, team_d;
  mode_e              mode_q, mode_d;
  logic [NS*4-1:0]    bcd_q, bcd_d;
  logic               sat_q, sat_d;
  logic [DW-1:0]      div_q, div_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [NS-1:0]      scan_sel_q, scan_sel_d;
  bcd_digit_t         scan_digit_q, scan_digit_d;

  logic [SW-1:0]      add_a, add_sum;
  logic [1:0]         add_inc;
  logic               add_sat;

`ifdef UNDO_EN
  logic               undo_valid_q, undo_valid_d;
  logic [TW-1:0]      undo_team_q, undo_team_d;
  logic [SW-1:0]      undo_score_q, undo_score_d;
  assign key_in = {I_key_undo, I_key_clear, I_key_count, I_key_mode, I_key_team};
`else
  logic unused_undo;
  assign unused_undo = I_key_undo;
  assign key_in = {1'b0, I_key_clear, I_key_count, I_key_mode, I_key_team};
`endif

  assign add_a   = bcd_q[int'(team_q)*SW +: SW];
  assign add_inc = mode_q + 2'd1;

  bcd_add_sat #(.N_DIGITS(N_DIGITS)) u_add (
    .I_a      (add_a),
    .I_addend (add_inc),
    .O_sum    (add_sum),
    .O_sat    (add_sat)
  );

  // Rising-edge detection; the event is registered so actions land one edge later
  always_comb begin
    key_d = key_in;
    evt_d = key_in & ~key_q;
  end

  // One action per cycle: clear > undo > count > mode > team
  always_comb begin
    bcd_d  = bcd_q;
    team_d = team_q;
    mode_d = mode_q;
    sat_d  = 1'b0;
`ifdef UNDO_EN
    undo_valid_d = undo_valid_q;
    undo_team_d  = undo_team_q;
    undo_score_d = undo_score_q;
`endif
    if (evt_q[K_CLEAR]) begin
      bcd_d = '0;
`ifdef UNDO_EN
      undo_valid_d = 1'b0;
`endif
    end else if (evt_q[K_UNDO]) begin
`ifdef UNDO_EN
      if (undo_valid_q) begin
        bcd_d[int'(undo_team_q)*SW +: SW] = undo_score_q;
        undo_valid_d = 1'b0;
      end
`endif
    end else if (evt_q[K_COUNT]) begin
      bcd_d[int'(team_q)*SW +: SW] = add_sum;
      sat_d = add_sat;
`ifdef UNDO_EN
      undo_valid_d = 1'b1;
      undo_team_d  = team_q;
      undo_score_d = add_a;
`endif
    end else if (evt_q[K_MODE]) begin
      case (mode_q)
        MODE_P1: mode_d = MODE_P2;
        MODE_P2: mode_d = MODE_P3;
        default: mode_d = MODE_P1;
      endcase
    end else if (evt_q[K_TEAM]) begin
      team_d = (team_q == TW'(N_TEAMS - 1)) ? '0 : team_q + 1'b1;
    end
  end

  // Scan divider/index and registered digit outputs
  always_comb begin
    div_d = div_q;
    idx_d = idx_q;
    if (div_q == DW'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IW'(NS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      div_d = div_q + 1'b1;
    end
    scan_sel_d        = '0;
    scan_sel_d[idx_q] = 1'b1;
    scan_digit_d      = bcd_q[int'(idx_q)*4 +: 4];
  end

  // State registers
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      key_q        <= '0;
      evt_q        <= '0;
      team_q       <= '0;
      mode_q       <= MODE_P1;
      bcd_q        <= '0;
      sat_q        <= 1'b0;
      div_q        <= '0;
      idx_q        <= '0;
      scan_sel_q   <= NS'(1);
      scan_digit_q <= '0;
`ifdef UNDO_EN
      undo_valid_q <= 1'b0;
      undo_team_q  <= '0;
      undo_score_q <= '0;
`endif
    end else begin
      key_q        <= key_d;
      evt_q        <= evt_d;
      team_q       <= team_d;
      mode_q       <= mode_d;
      bcd_q        <= bcd_d;
      sat_q        <= sat_d;
      div_q        <= div_d;
      idx_q        <= idx_d;
      scan_sel_q   <= scan_sel_d;
      scan_digit_q <= scan_digit_d;
`ifdef UNDO_EN
      undo_valid_q <= undo_valid_d;
      undo_team_q  <= undo_team_d;
      undo_score_q <= undo_score_d;
`endif
    end
  end

  assign O_team_sel   = team_q;
  assign O_mode       = mode_q;
  assign O_bcd        = bcd_q;
  assign O_sat        = sat_q;
  assign O_scan_sel   = scan_sel_q;
  assign O_scan_digit = scan_digit_q;

endmodule
